// File: rtl/msrv32_pkg.sv
// Shared types and constants for the msrv32 pipeline sequencing controller.
// Provides the FSM state encoding, default parameters and the x0 index.
package msrv32_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_LD_STALL = 2'd1,
    ST_MEM_WAIT = 2'd2,
    ST_FLUSH    = 2'd3
  } state_e;

  localparam int unsigned FLUSH_CYCLES_DEF = 1;
  localparam int unsigned CNT_W_DEF        = 16;
  localparam int unsigned REG_AW           = 5;
  localparam int unsigned FCNT_W           = 4;
  localparam logic [REG_AW-1:0] X0_IDX     = '0;

endpackage

// File: rtl/msrv32_pipe_ctrl_if.sv
// Control/status bundle between the core pipeline and msrv32_pipe_ctrl.
// master: pipeline side (drives redirects, hazard info, dmem busy, counter clear)
// slave : controller side (drives stall/flush, state and performance counters)
interface msrv32_pipe_ctrl_if #(
  parameter int unsigned CNT_W = msrv32_pkg::CNT_W_DEF
);
  logic                              branch_taken_in;
  logic                              trap_taken_in;
  logic                              ld_in_s3_in;
  logic [msrv32_pkg::REG_AW-1:0]     rd_addr_s3_in;
  logic [msrv32_pkg::REG_AW-1:0]     rs1_addr_s2_in;
  logic [msrv32_pkg::REG_AW-1:0]     rs2_addr_s2_in;
  logic                              rs1_used_in;
  logic                              rs2_used_in;
  logic                              dmem_busy_in;
  logic                              clr_cnt_in;
  logic                              stall_out;
  logic                              flush_out;
  logic [1:0]                        state_out;
  logic [CNT_W-1:0]                  stall_cnt_out;
  logic [CNT_W-1:0]                  flush_cnt_out;

  modport master (
    output branch_taken_in, trap_taken_in, ld_in_s3_in, rd_addr_s3_in,
           rs1_addr_s2_in, rs2_addr_s2_in, rs1_used_in, rs2_used_in,
           dmem_busy_in, clr_cnt_in,
    input  stall_out, flush_out, state_out, stall_cnt_out, flush_cnt_out
  );

  modport slave (
    input  branch_taken_in, trap_taken_in, ld_in_s3_in, rd_addr_s3_in,
           rs1_addr_s2_in, rs2_addr_s2_in, rs1_used_in, rs2_used_in,
           dmem_busy_in, clr_cnt_in,
    output stall_out, flush_out, state_out, stall_cnt_out, flush_cnt_out
  );
endinterface

// File: rtl/msrv32_hazard_detect.sv
// Combinational load-use hazard detect between stage 3 (load) and stage 2 (sources).
// Ports: ld_s3_i/rd_s3_i describe the stage-3 load, rs*_s2_i/rs*_used_i the
// stage-2 reads; hazard_c is high when a used source matches a non-x0 load rd.
module msrv32_hazard_detect
  import msrv32_pkg::*;
(
  input  logic              ld_s3_i,
  input  logic [REG_AW-1:0] rd_s3_i,
  input  logic [REG_AW-1:0] rs1_s2_i,
  input  logic [REG_AW-1:0] rs2_s2_i,
  input  logic              rs1_used_i,
  input  logic              rs2_used_i,
  output logic              hazard_c
);

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit  = rs1_used_i && (rs1_s2_i == rd_s3_i);
  assign rs2_hit  = rs2_used_i && (rs2_s2_i == rd_s3_i);
  // Writes to x0 are discarded, so they never create a dependency.
  assign hazard_c = ld_s3_i && (rd_s3_i != X0_IDX) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/msrv32_pipe_ctrl.sv
// Pipeline sequencing controller: per cycle chooses capture, stall or bubble for
// reg_block_2. Priority is redirect > dmem busy > load-use hazard.
// Ports: clk_in, reset_n_in (async active-low), bus (slave modport) carrying the
// redirect/hazard/busy inputs and the stall/flush/state/counter outputs.
// stall_out/flush_out are combinational from state and current inputs.
module msrv32_pipe_ctrl
  import msrv32_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = FLUSH_CYCLES_DEF,
  parameter int unsigned CNT_W        = CNT_W_DEF
) (
  input  logic               clk_in,
  input  logic               reset_n_in,
  msrv32_pipe_ctrl_if.slave  bus
);

  localparam logic [FCNT_W-1:0] FLUSH_RELOAD = FCNT_W'(FLUSH_CYCLES - 1);
  localparam logic              MULTI_FLUSH  = (FLUSH_CYCLES > 1);
  localparam logic [CNT_W-1:0]  CNT_MAX      = '1;

  state_e             state_q, state_d;
  logic [FCNT_W-1:0]  cnt_q, cnt_d;
  logic               pend_q, pend_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;

  logic hazard_c;
  logic redirect_c;
  logic take_redir_c;
  logic stall_c;
  logic flush_c;
  logic stall_g_c;
  logic flush_g_c;

  msrv32_hazard_detect u_hazard (
    .ld_s3_i    (bus.ld_in_s3_in),
    .rd_s3_i    (bus.rd_addr_s3_in),
    .rs1_s2_i   (bus.rs1_addr_s2_in),
    .rs2_s2_i   (bus.rs2_addr_s2_in),
    .rs1_used_i (bus.rs1_used_in),
    .rs2_used_i (bus.rs2_used_in),
    .hazard_c   (hazard_c)
  );

  assign redirect_c = bus.branch_taken_in || bus.trap_taken_in;

  // Next-state and stall/flush decode.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pend_d       = pend_q;
    stall_c      = 1'b0;
    flush_c      = 1'b0;
    take_redir_c = 1'b0;
    unique case (state_q)
      ST_RUN, ST_LD_STALL: begin
        if (redirect_c) begin
          take_redir_c = 1'b1;
        end else if (bus.dmem_busy_in) begin
          stall_c = 1'b1;
          state_d = ST_MEM_WAIT;
        end else if (hazard_c && (state_q == ST_RUN)) begin
          // Hold the consumer one cycle and bubble the slot behind the load.
          stall_c = 1'b1;
          flush_c = 1'b1;
          state_d = ST_LD_STALL;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_MEM_WAIT: begin
        if (bus.dmem_busy_in) begin
          // Redirect is deferred until memory releases the pipeline.
          stall_c = 1'b1;
          if (redirect_c) pend_d = 1'b1;
        end else begin
          pend_d = 1'b0;
          if (pend_q || redirect_c) take_redir_c = 1'b1;
          else                      state_d      = ST_RUN;
        end
      end
      ST_FLUSH: begin
        flush_c = 1'b1;
        if (redirect_c) begin
          cnt_d = FLUSH_RELOAD;
        end else if (cnt_q <= FCNT_W'(1)) begin
          cnt_d   = '0;
          state_d = ST_RUN;
        end else begin
          cnt_d = cnt_q - FCNT_W'(1);
        end
      end
      default: state_d = ST_RUN;
    endcase

    // The redirect cycle is itself the first bubble; FLUSH covers the rest.
    if (take_redir_c) begin
      flush_c = 1'b1;
      if (MULTI_FLUSH) begin
        state_d = ST_FLUSH;
        cnt_d   = FLUSH_RELOAD;
      end else begin
        state_d = ST_RUN;
        cnt_d   = '0;
      end
    end
  end

  // Outputs are forced low while reset is asserted, independent of the clock.
  assign stall_g_c = stall_c && reset_n_in;
  assign flush_g_c = flush_c && reset_n_in;

  // Saturating performance counters; clear wins over increment.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (bus.clr_cnt_in) begin
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end else begin
      if (stall_g_c && (stall_cnt_q != CNT_MAX)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
      if (flush_g_c && (flush_cnt_q != CNT_MAX)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  // State register.
  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state_q     <= ST_RUN;
      cnt_q       <= '0;
      pend_q      <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pend_q      <= pend_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign bus.stall_out     = stall_g_c;
  assign bus.flush_out     = flush_g_c;
  assign bus.state_out     = state_q;
  assign bus.stall_cnt_out = stall_cnt_q;
  assign bus.flush_cnt_out = flush_cnt_q;

endmodule

// File: doc/msrv32_pipe_ctrl.md
# msrv32_pipe_ctrl

Pipeline sequencing controller for the msrv32 core. It decides every cycle whether the stage-2/stage-3 pipeline register (`msrv32_reg_block_2`) captures normally, holds the upstream stages (stall), or captures a bubble (flush). Inputs are branch/trap redirects, data-memory back-pressure and load-use hazards. It sits beside `msrv32_reg_block_2` and drives its hold/bubble controls plus the PC and stage-1 hold.

## Interface
- `FLUSH_CYCLES`, default 1: bubble cycles per redirect, legal range 1..15.
- `CNT_W`, default 16: width of the performance counters.

- `clk_in`  in  1  core clock, rising edge.
- `reset_n_in`  in  1  asynchronous, active-low reset.
- `branch_taken_in`  in  1  stage-3 branch/jump resolved taken.
- `trap_taken_in`  in  1  trap, interrupt or mret redirect.
- `ld_in_s3_in`  in  1  instruction held in reg_block_2 is a load with `rf_wr_en` set.
- `rd_addr_s3_in`  in  5  destination register of that instruction.
- `rs1_addr_s2_in`, `rs2_addr_s2_in`  in  5 each  stage-2 source registers.
- `rs1_used_in`, `rs2_used_in`  in  1 each  stage-2 instruction reads rs1/rs2.
- `dmem_busy_in`  in  1  data memory has not acknowledged the current access.
- `clr_cnt_in`  in  1  synchronous clear of both counters.
- `stall_out`  out  1  hold PC, reg_block_1 and reg_block_2.
- `flush_out`  out  1  reg_block_2 captures a bubble: `rf_wr_en`, `csr_wr_en` and `branch_taken` are forced to 0.
- `state_out`  out  2  current FSM state.
- `stall_cnt_out`, `flush_cnt_out`  out  CNT_W each  saturating cycle counters.

## Operation
- Signal definitions:
  - hazard = ld_in_s3 & (rd_addr_s3 != 0) & ((rs1_used & rs1 == rd) | (rs2_used & rs2 == rd)).
  - redirect = branch_taken | trap_taken.
- Per-cycle priority: redirect > dmem_busy > hazard.
- States: RUN=0, LD_STALL=1, MEM_WAIT=2, FLUSH=3.
- RUN:
  - redirect: flush_out=1. Next state is FLUSH with cnt=FLUSH_CYCLES-1 if FLUSH_CYCLES>1, else RUN.
  - else dmem_busy: stall_out=1, next MEM_WAIT.
  - else hazard: stall_out=1 and flush_out=1 (a one-bubble insert), next LD_STALL.
  - else both outputs 0.
- LD_STALL:
  - hazard is ignored.
  - redirect and dmem_busy are handled as in RUN.
  - Otherwise outputs are 0 and the next state is RUN.
- MEM_WAIT:
  - stall_out=1 while dmem_busy.
  - A redirect seen here sets `pend_q` and produces no flush yet.
  - On the first cycle with dmem_busy=0: stall_out=0. If (pend_q | redirect), flush_out=1 and the redirect rules apply; otherwise next RUN. pend_q clears.
- FLUSH:
  - flush_out=1 and stall_out=0.
  - cnt decrements each cycle; next RUN when cnt==0.
  - A new redirect reloads cnt=FLUSH_CYCLES-1.
- Counters:
  - stall_cnt increments on every cycle with stall_out=1; flush_cnt on every cycle with flush_out=1.
  - Both saturate at all-ones.
  - clr_cnt_in has priority over increment; the cleared value is 0 on the next cycle.

## Timing
- stall_out and flush_out are combinational from state plus the current inputs, so they take effect at the same edge. There is no added latency.
- state, cnt, pend_q and the counters update on the rising clk_in.
- Reset (reset_n_in=0), asynchronous, immediate:
  - state=RUN, cnt=0, pend_q=0, both counters 0.
  - stall_out=0 and flush_out=0, forced regardless of inputs.
  - state_out=0.
- Reset released mid-stall or mid-flush: operation restarts in RUN and any pending redirect is lost.
- Load-use penalty is exactly 1 stall cycle. Redirect penalty is exactly FLUSH_CYCLES bubbles, plus any memory-wait cycles in progress.

## Structure
- `msrv32_pkg` holds:
  - the state encoding constants
  - the default FLUSH_CYCLES
  - the x0 register index constant
- Sub-module `msrv32_hazard_detect` is purely combinational and produces `hazard` from the s3/s2 address and use ports.
- The FSM, down-counter, pend_q and performance counters live in `msrv32_pipe_ctrl`.

## Test plan
- Load x5 in s3, s2 reads rs1=x5 with rs1_used=1 → one cycle with stall_out=1 and flush_out=1 in RUN; LD_STALL next; RUN after; stall_cnt=1.
- rd_addr_s3=0 with rs1=0 and a load → no stall. rs2 match with rs2_used=0 → no stall.
- FLUSH_CYCLES=3, branch_taken pulse for 1 cycle → flush_out high for 3 consecutive cycles, state sequence RUN,FLUSH,FLUSH,RUN; flush_cnt=3.
- dmem_busy high 4 cycles with trap_taken pulsed in the 2nd → stall_out for 4 cycles, then flush_out on the release cycle, pend_q cleared.
- Simultaneous branch_taken, dmem_busy and hazard in RUN → flush_out=1 and stall_out=0 (redirect wins).
- reset_n_in asserted mid-FLUSH, then clr_cnt_in with a counter at 0xFFFF → outputs go to 0 asynchronously and state_out=0. Counters saturate at 0xFFFF and clear to 0 on the next cycle.
